uart_rx_periph: RTL and testbench

APB slave UART receiver; the downstream partner of the UART TX peripheral, consuming its `tx` serial line.
- Oversamples the `rx` line at 16x and deframes 8N1 characters (8 data bits, no parity, 1 stop bit).
- Pushes each received byte into a small RX FIFO.
- Exposes status, data, baud and control registers on APB, using the same register layout as the TX peripheral.
- Used for TX→RX loopback and for host receive paths.

---
 rtl/uart_rx_periph.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_periph.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_periph.sv
// -----------------------------------------------------------------------------
// uart_rx_periph -- APB slave UART receiver (8N1, 16x oversampling, RX FIFO)
//
// Purpose:
//   Samples the asynchronous `rx` line through a two-flop synchronizer.
//   Deframes 8N1 characters on ticks from a programmable baud tick generator.
//   Pushes each good byte into a small FIFO that the host reads over APB.
//
// Ports:
//   PCLK      in   system/APB clock (only clock)
//   PRESET    in   asynchronous active-low reset
//   PADDR     in   [4:0] APB byte address
//   PWDATA    in   [31:0] APB write data
//   PWRITE    in   1 = write, 0 = read
//   PENABLE   in   APB access phase
//   PSEL      in   APB slave select
//   PRDATA    out  [31:0] read data (combinational in access phase, else 0)
//   PREADY    out  PSEL & PENABLE (no wait states)
//   rx        in   serial input, idle high
//   irq       out  interrupt, only when UART_RX_IRQ_EN is defined
//
// Register map:
//   0x00 FSR  [0] rx_empty [1] rx_full [2] overrun(W1C) [3] frame_err(W1C) [4] rx_busy
//   0x08 RDR  [7:0] FIFO head; a read pops one entry
//   0x0C BRR  [15:0] PCLK cycles per oversample tick (0 behaves as 1)
//   0x10 UCR  [0] enable [1] rx_enable [2] flush (self-clearing) [3] irq_en
//
// Build option:
//   UART_RX_IRQ_EN : adds the registered `irq` output and UCR[3] irq_en.
//                    When it is undefined, UCR[3] reads 0 and ignores writes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx_periph #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVS        = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        rx
`ifdef UART_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] SMP_MID  = 4'(OVS / 2 - 1);  // mid-point of the start bit
  localparam logic [3:0] SMP_LAST = 4'(OVS - 1);      // one bit period after a mid-point

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [15:0] brr_q, tick_cnt_q, tick_cnt_d, tick_max;
  logic        en_q, rx_en_q, run, tick;
  logic [3:0]  smp_q, smp_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        push, frame_evt;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, pop, flush, do_push, ovr_evt;
  logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic        acc, wr, rd, sel_fsr, sel_rdr, sel_brr, sel_ucr;
  logic        unused_pwdata;
`ifdef UART_RX_IRQ_EN
  logic        irq_en_q, irq_q;
`endif

  assign unused_pwdata = ^PWDATA[31:16];

  // ---------------- APB decode ----------------
  assign acc     = PSEL & PENABLE;
  assign wr      = acc & PWRITE;
  assign rd      = acc & ~PWRITE;
  assign sel_fsr = (PADDR == 5'h00);
  assign sel_rdr = (PADDR == 5'h08);
  assign sel_brr = (PADDR == 5'h0C);
  assign sel_ucr = (PADDR == 5'h10);
  assign PREADY  = acc;

  // ---------------- FIFO status ----------------
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop     = rd & sel_rdr & ~empty;
  assign flush   = wr & sel_ucr & PWDATA[2];
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | pop) & ~flush;
  assign ovr_evt = push & full & ~pop & ~flush;

  // ---------------- tick generator ----------------
  assign run      = en_q & rx_en_q;
  assign tick_max = (brr_q == 16'd0) ? 16'd0 : brr_q - 16'd1;
  // >= rather than == so that lowering BRR mid-count still reloads promptly.
  assign tick     = run & (tick_cnt_q >= tick_max);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 16'd1;
    if (!run || tick) tick_cnt_d = 16'd0;
  end

  // ---------------- receive FSM ----------------
  always_comb begin
    state_d   = state_q;
    smp_d     = smp_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_evt = 1'b0;
    if (!run) begin
      state_d = S_IDLE;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            state_d = S_START;
            smp_d   = 4'd0;
          end
        end
        S_START: begin
          smp_d = smp_q + 4'd1;
          if (smp_q == SMP_MID) begin
            smp_d = 4'd0;
            bit_d = 3'd0;
            state_d = rx_sync_q ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          smp_d = smp_q + 4'd1;  // wraps to 0 after SMP_LAST
          if (smp_q == SMP_LAST) begin
            shift_d = {rx_sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          smp_d = smp_q + 4'd1;
          if (smp_q == SMP_LAST) begin
            if (rx_sync_q) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_evt = 1'b1;
              state_d   = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (rx_sync_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- sticky error flags (set beats W1C) ----------------
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr && sel_fsr && PWDATA[2]) overrun_d   = 1'b0;
    if (wr && sel_fsr && PWDATA[3]) frame_err_d = 1'b0;
    if (ovr_evt)   overrun_d   = 1'b1;
    if (frame_evt) frame_err_d = 1'b1;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      smp_q       <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      tick_cnt_q  <= 16'd0;
      brr_q       <= 16'd0;
      en_q        <= 1'b0;
      rx_en_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      smp_q       <= smp_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      tick_cnt_q  <= tick_cnt_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      if (wr && sel_brr) brr_q <= PWDATA[15:0];
      if (wr && sel_ucr) begin
        en_q    <= PWDATA[0];
        rx_en_q <= PWDATA[1];
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; the pointers define validity.
  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

`ifdef UART_RX_IRQ_EN
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr && sel_ucr) irq_en_q <= PWDATA[3];
      irq_q <= irq_en_q & (~empty | overrun_q | frame_err_q);
    end
  end
  assign irq = irq_q;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    PRDATA = 32'd0;
    if (rd) begin
      if (sel_fsr)
        PRDATA = {27'd0, (state_q != S_IDLE), frame_err_q, overrun_q, full, empty};
      else if (sel_rdr)
        PRDATA = empty ? 32'd0 : {24'd0, mem_q[rd_ptr_q[AW-1:0]]};
      else if (sel_brr)
        PRDATA = {16'd0, brr_q};
      else if (sel_ucr)
`ifdef UART_RX_IRQ_EN
        PRDATA = {28'd0, irq_en_q, 1'b0, rx_en_q, en_q};
`else
        PRDATA = {30'd0, rx_en_q, en_q};
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_periph.sv
`timescale 1ns/1ps
module tb_uart_rx_periph;

  localparam logic [4:0] A_FSR = 5'h00, A_RDR = 5'h08, A_BRR = 5'h0C, A_UCR = 5'h10;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [4:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        rx = 1'b1;
`ifdef UART_RX_IRQ_EN
  logic        irq;
`endif

  int total = 0;
  int bad   = 0;
  int bit_ns = 2560;  // 16 * BRR(0x10) * 10 ns

  always #5 PCLK = ~PCLK;

  uart_rx_periph #(.FIFO_DEPTH(4), .OVS(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA(PRDATA), .PREADY(PREADY), .rx(rx)
`ifdef UART_RX_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("wr   addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic apb_rd(input logic [4:0] a, output logic [31:0] d,
                        output logic rdy_setup, output logic rdy_acc);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    #1 rdy_setup = PREADY;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA; rdy_acc = PREADY;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic rs, ra;
    apb_rd(a, d, rs, ra);
    chk(name, d, exp);
  endtask

  // 8N1 frame; with stop=0 the line is left low afterwards.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic rs, ra;
    logic [7:0] burst [4];

    tbl[0]  = '{1'b0, A_FSR, 32'h0, 32'h0000_0001, "reset FSR"};
    tbl[1]  = '{1'b0, A_RDR, 32'h0, 32'h0000_0000, "reset RDR"};
    tbl[2]  = '{1'b0, A_BRR, 32'h0, 32'h0000_0000, "reset BRR"};
    tbl[3]  = '{1'b0, A_UCR, 32'h0, 32'h0000_0000, "reset UCR"};
    tbl[4]  = '{1'b0, 5'h04, 32'h0, 32'h0000_0000, "reset 0x04"};
    tbl[5]  = '{1'b1, 5'h04, 32'hFFFF_FFFF, 32'h0, "wr 0x04"};
    tbl[6]  = '{1'b0, 5'h04, 32'h0, 32'h0000_0000, "0x04 ignores wr"};
    tbl[7]  = '{1'b0, 5'h14, 32'h0, 32'h0000_0000, "unmapped 0x14"};
    tbl[8]  = '{1'b1, A_FSR, 32'hFFFF_FFFF, 32'h0, "wr FSR all ones"};
    tbl[9]  = '{1'b0, A_FSR, 32'h0, 32'h0000_0001, "FSR RO bits"};
    tbl[10] = '{1'b1, A_BRR, 32'h1234_0010, 32'h0, "wr BRR"};
    tbl[11] = '{1'b0, A_BRR, 32'h0, 32'h0000_0010, "BRR readback"};
    tbl[12] = '{1'b1, A_UCR, 32'h0000_000B, 32'h0, "wr UCR"};
`ifdef UART_RX_IRQ_EN
    tbl[13] = '{1'b0, A_UCR, 32'h0, 32'h0000_000B, "UCR readback"};
`else
    tbl[13] = '{1'b0, A_UCR, 32'h0, 32'h0000_0003, "UCR readback"};
`endif

    // reset held for 2 cycles
    PRESET = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESET = 1'b1;

    // PREADY only in the access phase; PRDATA idles at 0
    apb_rd(A_FSR, d, rs, ra);
    chk("PREADY setup", {31'd0, rs}, 32'd0);
    chk("PREADY access", {31'd0, ra}, 32'd1);
    #1 chk("PREADY idle", {31'd0, PREADY}, 32'd0);
    chk("PRDATA idle", PRDATA, 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) apb_wr(tbl[i].addr, tbl[i].wdata);
      else rd_chk(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end

    // single frame; rx_busy seen mid-frame
    fork
      send_frame(8'hA5, 1'b1);
      begin
        #(bit_ns * 4);
        rd_chk("busy mid-frame", A_FSR, 32'h0000_0011);
      end
    join
    rd_chk("FSR after A5", A_FSR, 32'h0000_0000);
    rd_chk("RDR A5", A_RDR, 32'h0000_00A5);
    rd_chk("FSR empty again", A_FSR, 32'h0000_0001);

    // overflow: 5 frames into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    rd_chk("FSR full+overrun", A_FSR, 32'h0000_0006);
    for (int i = 1; i <= 4; i++) rd_chk("RDR ordered", A_RDR, 32'(i));
    rd_chk("RDR empty read", A_RDR, 32'h0000_0000);
    rd_chk("FSR overrun sticky", A_FSR, 32'h0000_0005);
    apb_wr(A_FSR, 32'h4);
    rd_chk("FSR overrun cleared", A_FSR, 32'h0000_0001);

    // framing error; FSM waits for idle line
    send_frame(8'h3C, 1'b0);
    #(bit_ns * 2);
    rd_chk("FSR frame_err busy", A_FSR, 32'h0000_0019);
    rx = 1'b1;
    #(bit_ns);
    rd_chk("FSR frame_err idle", A_FSR, 32'h0000_0009);
    apb_wr(A_FSR, 32'h8);
    rd_chk("FSR frame_err cleared", A_FSR, 32'h0000_0001);
    send_frame(8'h3C, 1'b1);
    rd_chk("RDR 3C after error", A_RDR, 32'h0000_003C);

    // 48-cycle low glitch
    rx = 1'b0;
    #480;
    rx = 1'b1;
    #(bit_ns * 2);
    rd_chk("FSR after glitch", A_FSR, 32'h0000_0001);

    // rx_enable dropped at data bit 4
    fork
      send_frame(8'hC3, 1'b1);
      begin
        #(bit_ns * 5 + bit_ns / 2);
        apb_wr(A_UCR, 32'h1);
      end
    join
    rd_chk("FSR after abort", A_FSR, 32'h0000_0001);
    apb_wr(A_UCR, 32'h3);
    send_frame(8'h5A, 1'b1);
    rd_chk("RDR 5A after re-enable", A_RDR, 32'h0000_005A);

    // back-to-back burst
    burst[0] = 8'hA5; burst[1] = 8'h5A; burst[2] = 8'h6A; burst[3] = 8'h7A;
    for (int i = 0; i < 4; i++) send_frame(burst[i], 1'b1);
    for (int i = 0; i < 4; i++) rd_chk("RDR burst", A_RDR, {24'd0, burst[i]});
    rd_chk("FSR after burst", A_FSR, 32'h0000_0001);

    // flush empties the FIFO and self-clears
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rd_chk("FSR two queued", A_FSR, 32'h0000_0000);
    apb_wr(A_UCR, 32'h7);
    rd_chk("UCR flush self-clear", A_UCR, 32'h0000_0003);
    rd_chk("FSR after flush", A_FSR, 32'h0000_0001);
    rd_chk("RDR after flush", A_RDR, 32'h0000_0000);

    // asynchronous reset mid-frame
    fork
      send_frame(8'h99, 1'b1);
      begin
        #(bit_ns * 4 + 3);
        PRESET = 1'b0;
        #30;
        PRESET = 1'b1;
      end
    join
    rd_chk("FSR after async reset", A_FSR, 32'h0000_0001);
    rd_chk("BRR after async reset", A_BRR, 32'h0000_0000);
    rd_chk("UCR after async reset", A_UCR, 32'h0000_0000);
    rd_chk("RDR after async reset", A_RDR, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
